// File: rtl/jtframe_snd_comm_pkg.sv
// jtframe_snd_comm_pkg
// Shared definitions for the main-to-sound communication block:
//   IRQ_LEVEL / IRQ_LATCH : encodings of the IRQ_MODE parameter
//   chan_width()          : width of a channel selector for a given channel count
package jtframe_snd_comm_pkg;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_LATCH = 1;

    // A single channel still needs a 1-bit selector port, so $clog2(1)=0 is guarded
    function automatic int chan_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/jtframe_snd_fifo.sv
// jtframe_snd_fifo
// One main-to-sound channel: circular buffer of 2**AW words with show-ahead output.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push, din : write strobe and word
//   pop       : read strobe (advances the head)
//   dout      : current head word, or FILL when empty
//   empty     : no words stored
//   full      : 2**AW words stored
//   ovf_set   : one-cycle pulse when a push is dropped because the buffer is full
module jtframe_snd_fifo
    import jtframe_snd_comm_pkg::*;
#(
    parameter int             DW   = 8,
    parameter int             AW   = 2,
    parameter logic [DW-1:0]  FILL = DW'(8'hFF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic          ovf_set
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full buffer still accepts a push when a pop frees the head slot in the same cycle
    assign do_push = push & (~full | do_pop);
    assign ovf_set = push & full & ~do_pop;
    assign dout    = empty ? FILL : mem[rd_ptr];

    // Storage is not reset; the cleared pointers make any stale words invisible
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jtframe_snd_comm.sv
// jtframe_snd_comm
// Main-CPU to sound-CPU communication: CH per-channel FIFOs, a selectable-mode IRQ
// and a sound-to-main reply latch with a "new data" flag.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   main_wr, main_ch, main_din    : push strobe, target channel, word
//   main_full, main_ovf, ovf_clr  : per-channel full, sticky overflow, overflow clear
//   main_reply, main_reply_new    : last reply word and its unread flag
//   main_reply_rd                 : clears main_reply_new
//   snd_rd, snd_ch, snd_dout      : pop strobe, channel select, show-ahead head word
//   snd_empty                     : per-channel empty
//   snd_wr, snd_din               : reply write strobe and word
//   irq_en, snd_irq_ack, snd_irq_n: IRQ enable mask, acknowledge, active-low IRQ
module jtframe_snd_comm
    import jtframe_snd_comm_pkg::*;
#(
    parameter int             DW       = 8,
    parameter int             AW       = 2,
    parameter int             CH       = 1,
    parameter int             IRQ_MODE = 1,
    parameter logic [DW-1:0]  FILL     = DW'(8'hFF)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        main_wr,
    input  logic [chan_width(CH)-1:0]   main_ch,
    input  logic [DW-1:0]               main_din,
    output logic [CH-1:0]               main_full,
    output logic [CH-1:0]               main_ovf,
    input  logic                        ovf_clr,
    output logic [DW-1:0]               main_reply,
    output logic                        main_reply_new,
    input  logic                        main_reply_rd,
    input  logic                        snd_rd,
    input  logic [chan_width(CH)-1:0]   snd_ch,
    output logic [DW-1:0]               snd_dout,
    output logic [CH-1:0]               snd_empty,
    input  logic                        snd_wr,
    input  logic [DW-1:0]               snd_din,
    input  logic [CH-1:0]               irq_en,
    input  logic                        snd_irq_ack,
    output logic                        snd_irq_n
);

    localparam int CW = chan_width(CH);

    logic [CH-1:0] push_v, pop_v, ovf_set, push_ok;
    logic [DW-1:0] fifo_dout [CH];
    logic          pending, pending_next;

    // Channel decode: selector values at or above CH match no channel and are ignored
    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign push_v[i]  = main_wr & (main_ch == CW'(i));
        assign pop_v[i]   = snd_rd  & (snd_ch  == CW'(i));
        assign push_ok[i] = push_v[i] & (~main_full[i] | pop_v[i]);

        jtframe_snd_fifo #(.DW(DW), .AW(AW), .FILL(FILL)) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .push   (push_v[i]),
            .din    (main_din),
            .pop    (pop_v[i]),
            .dout   (fifo_dout[i]),
            .empty  (snd_empty[i]),
            .full   (main_full[i]),
            .ovf_set(ovf_set[i])
        );
    end

    // Read mux; an out-of-range selector reads as an empty channel
    always_comb begin
        snd_dout = FILL;
        for (int i = 0; i < CH; i++) begin
            if (snd_ch == CW'(i)) snd_dout = fifo_dout[i];
        end
    end

    // Sticky overflow flags: a new overflow beats a clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) main_ovf <= '0;
        else     main_ovf <= ovf_set | (main_ovf & ~{CH{ovf_clr}});
    end

    // Latched mode: a push beats an acknowledge in the same cycle
    assign pending_next = (|(push_ok & irq_en)) | (pending & ~snd_irq_ack);

    // The IRQ output is always a register so the sound CPU never sees decode glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            snd_irq_n <= 1'b1;
        end else if (IRQ_MODE == IRQ_LATCH) begin
            pending   <= pending_next;
            snd_irq_n <= ~pending_next;
        end else begin
            pending   <= 1'b0;
            snd_irq_n <= ~|(~snd_empty & irq_en);
        end
    end

    // Reply latch: a fresh write keeps the flag set even if read in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            main_reply     <= '0;
            main_reply_new <= 1'b0;
        end else if (snd_wr) begin
            main_reply     <= snd_din;
            main_reply_new <= 1'b1;
        end else if (main_reply_rd) begin
            main_reply_new <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtframe_snd_comm.sv
// tb_jtframe_snd_comm
// Directed bench: two instances (latched and level IRQ) share every input, so FIFO and
// reply behaviour is checked on the latched one and each IRQ style on its own instance.
module tb_jtframe_snd_comm;

    logic       clk = 1'b0;
    logic       rst, main_wr, ovf_clr, main_reply_rd, snd_rd, snd_wr, snd_irq_ack;
    logic [0:0] main_ch, snd_ch;
    logic [7:0] main_din, snd_din;
    logic [1:0] irq_en;

    logic [1:0] main_full, main_ovf, snd_empty;
    logic [7:0] main_reply, snd_dout;
    logic       main_reply_new, snd_irq_n;

    logic [1:0] v_full, v_ovf, v_empty;
    logic [7:0] v_reply, v_dout;
    logic       v_reply_new, v_irq_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtframe_snd_comm #(.DW(8), .AW(2), .CH(2), .IRQ_MODE(1), .FILL(8'hFF)) dut (
        .clk(clk), .rst(rst), .main_wr(main_wr), .main_ch(main_ch), .main_din(main_din),
        .main_full(main_full), .main_ovf(main_ovf), .ovf_clr(ovf_clr),
        .main_reply(main_reply), .main_reply_new(main_reply_new), .main_reply_rd(main_reply_rd),
        .snd_rd(snd_rd), .snd_ch(snd_ch), .snd_dout(snd_dout), .snd_empty(snd_empty),
        .snd_wr(snd_wr), .snd_din(snd_din), .irq_en(irq_en), .snd_irq_ack(snd_irq_ack),
        .snd_irq_n(snd_irq_n)
    );

    jtframe_snd_comm #(.DW(8), .AW(2), .CH(2), .IRQ_MODE(0), .FILL(8'hFF)) dut_lvl (
        .clk(clk), .rst(rst), .main_wr(main_wr), .main_ch(main_ch), .main_din(main_din),
        .main_full(v_full), .main_ovf(v_ovf), .ovf_clr(ovf_clr),
        .main_reply(v_reply), .main_reply_new(v_reply_new), .main_reply_rd(main_reply_rd),
        .snd_rd(snd_rd), .snd_ch(snd_ch), .snd_dout(v_dout), .snd_empty(v_empty),
        .snd_wr(snd_wr), .snd_din(snd_din), .irq_en(irq_en), .snd_irq_ack(snd_irq_ack),
        .snd_irq_n(v_irq_n)
    );

    // Counts one comparison and reports it when the observed value differs
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one clock cycle of push/pop/ack strobes, then samples 1 time unit after the edge
    task automatic applyStimulus(input logic wr, input logic wch, input logic [7:0] wd,
                                 input logic rd, input logic rch, input logic ack);
        main_wr = wr; main_ch = wch; main_din = wd;
        snd_rd = rd; snd_ch = rch; snd_irq_ack = ack;
        @(posedge clk); #1;
        main_wr = 1'b0; snd_rd = 1'b0; snd_irq_ack = 1'b0;
        ovf_clr = 1'b0; snd_wr = 1'b0; main_reply_rd = 1'b0;
    endtask

    initial begin
        logic [7:0] expv [4];
        rst = 1'b1; main_wr = 0; main_ch = 0; main_din = 0; ovf_clr = 0; main_reply_rd = 0;
        snd_rd = 0; snd_ch = 0; snd_wr = 0; snd_din = 0; irq_en = 2'b01; snd_irq_ack = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        checkOutput("rst_empty", 32'(snd_empty), 32'h3);
        checkOutput("rst_full", 32'(main_full), 32'h0);
        checkOutput("rst_ovf", 32'(main_ovf), 32'h0);
        checkOutput("rst_dout", 32'(snd_dout), 32'hFF);
        checkOutput("rst_irq_latch", 32'(snd_irq_n), 32'h1);
        checkOutput("rst_irq_level", 32'(v_irq_n), 32'h1);
        checkOutput("rst_reply_new", 32'(main_reply_new), 32'h0);
        checkOutput("rst_reply", 32'(main_reply), 32'h0);

        // Channel isolation and latched IRQ
        applyStimulus(1, 1, 8'hA0, 0, 0, 0);
        checkOutput("irq_masked_ch1", 32'(snd_irq_n), 32'h1);
        checkOutput("lvl_masked_ch1", 32'(v_irq_n), 32'h1);
        applyStimulus(1, 0, 8'h5C, 0, 0, 0);
        checkOutput("irq_set_ch0", 32'(snd_irq_n), 32'h0);
        checkOutput("lvl_lag", 32'(v_irq_n), 32'h1);
        snd_ch = 1; #1;
        checkOutput("iso_dout_ch1", 32'(snd_dout), 32'hA0);
        snd_ch = 0; #1;
        checkOutput("iso_dout_ch0", 32'(snd_dout), 32'h5C);
        applyStimulus(0, 0, 8'h00, 1, 1, 0);
        checkOutput("iso_empty", 32'(snd_empty), 32'h2);
        checkOutput("iso_dout_ch1_fill", 32'(snd_dout), 32'hFF);
        checkOutput("lvl_irq_on", 32'(v_irq_n), 32'h0);
        applyStimulus(1, 0, 8'h5D, 0, 0, 1);
        checkOutput("irq_push_beats_ack", 32'(snd_irq_n), 32'h0);
        applyStimulus(0, 0, 8'h00, 0, 0, 1);
        checkOutput("irq_ack", 32'(snd_irq_n), 32'h1);

        // Drain ch0 and watch the level IRQ release one cycle after the last pop
        checkOutput("drain_head0", 32'(snd_dout), 32'h5C);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);
        checkOutput("drain_head1", 32'(snd_dout), 32'h5D);
        checkOutput("lvl_hold1", 32'(v_irq_n), 32'h0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);
        checkOutput("lvl_hold2", 32'(v_irq_n), 32'h0);
        checkOutput("drain_empty", 32'(snd_empty), 32'h3);
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("lvl_release", 32'(v_irq_n), 32'h1);

        // Ordering, full and overflow
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 8'h11 + 8'(i), 0, 0, 0);
            checkOutput($sformatf("full_after_%0d", i + 1), 32'(main_full[0]), (i >= 3) ? 32'h1 : 32'h0);
            checkOutput($sformatf("ovf_after_%0d", i + 1), 32'(main_ovf[0]), (i >= 4) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("order_%0d", i), 32'(snd_dout), 32'h11 + 32'(i));
            applyStimulus(0, 0, 8'h00, 1, 0, 0);
        end
        checkOutput("order_empty", 32'(snd_empty[0]), 32'h1);
        checkOutput("order_fill", 32'(snd_dout), 32'hFF);
        applyStimulus(0, 0, 8'h00, 1, 0, 0);
        checkOutput("pop_on_empty", 32'(snd_empty[0]), 32'h1);
        ovf_clr = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("ovf_clr", 32'(main_ovf), 32'h0);

        // Full FIFO with simultaneous push and pop; overflow set beats clear
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 8'h21 + 8'(i), 0, 0, 0);
        applyStimulus(1, 0, 8'h77, 1, 0, 0);
        checkOutput("fullpp_ovf", 32'(main_ovf[0]), 32'h0);
        checkOutput("fullpp_full", 32'(main_full[0]), 32'h1);
        ovf_clr = 1'b1;
        applyStimulus(1, 0, 8'h88, 0, 0, 0);
        checkOutput("ovf_set_beats_clr", 32'(main_ovf[0]), 32'h1);
        expv[0] = 8'h22; expv[1] = 8'h23; expv[2] = 8'h24; expv[3] = 8'h77;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("fullpp_order_%0d", i), 32'(snd_dout), 32'(expv[i]));
            applyStimulus(0, 0, 8'h00, 1, 0, 0);
        end
        checkOutput("fullpp_empty", 32'(snd_empty[0]), 32'h1);

        // Reply latch
        snd_wr = 1'b1; snd_din = 8'h3C; main_reply_rd = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("reply_data", 32'(main_reply), 32'h3C);
        checkOutput("reply_new_wr_beats_rd", 32'(main_reply_new), 32'h1);
        main_reply_rd = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 0, 0);
        checkOutput("reply_new_cleared", 32'(main_reply_new), 32'h0);
        checkOutput("reply_data_held", 32'(main_reply), 32'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
